// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the pipe transmit arbiter and the host-side deframer:
// FSM state encoding, header tag and header field positions.
package pipe_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam int WORD_W = 16;   // pipe word width
    localparam int CH_W   = 4;    // channel index width
    localparam int LEN_W  = 8;    // burst length / word counter width

    // Header word layout: {tag[15:12], channel[11:8], length[7:0]}.
    localparam logic [3:0] HDR_TAG     = 4'hC;
    localparam int         HDR_TAG_LSB = 12;
    localparam int         HDR_CH_LSB  = 8;
    localparam int         HDR_LEN_LSB = 0;

    // Build a header word from channel and burst length.
    function automatic logic [WORD_W-1:0] make_header(input logic [CH_W-1:0]  ch,
                                                      input logic [LEN_W-1:0] len);
        logic [WORD_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_TAG_LSB +: 4]     = HDR_TAG;
        hdr[HDR_CH_LSB  +: CH_W]  = ch;
        hdr[HDR_LEN_LSB +: LEN_W] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/pipe_tx_arbiter_rr_pick.sv
// Combinational round-robin priority select: the search starts one past the
// pointer and wraps at N; returns the winner as one-hot and as an index.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] grant,
    output logic [3:0]   idx
);

    // Walk candidates ptr+1, ptr+2, ... modulo N; the first requester wins.
    always_comb begin
        logic       found;
        logic [4:0] cand;
        // NOTE: every variable written here gets a default before the loops;
        // a path that skipped an assignment would infer a latch.
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        grant = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr} + 5'(i);
            if (cand >= 5'(N)) begin
                cand = cand - 5'(N);
            end
            for (int c = 0; c < N; c++) begin
                if (!found && req[c] && (cand == 5'(c))) begin
                    found    = 1'b1;
                    idx      = 4'(c);
                    grant[c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_tx_arbiter.sv
// Pipe transmit arbiter: grants one requester at a time round-robin, sends a
// header word {C, channel, length} and then up to MAX_BURST data words from
// that requester straight onto the host pipe sys_tx port.
module pipe_tx_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic [16*CHANNELS-1:0]   req_avail,
    input  logic [CHANNELS-1:0]      req_valid,
    input  logic [16*CHANNELS-1:0]   req_data,
    output logic [CHANNELS-1:0]      req_ready,
    output logic                     tx_valid,
    output logic [WORD_W-1:0]        tx_data,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_ch
);

    localparam logic [15:0]     MAX_BURST_W = 16'(MAX_BURST);
    localparam logic [CH_W-1:0] PTR_RESET   = 4'(CHANNELS - 1);

    arb_state_e          state_q, state_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;

    logic [CHANNELS-1:0] avail_nz;
    logic [CHANNELS-1:0] pick_onehot;
    logic [CH_W-1:0]     pick_idx;
    logic                pick_any;
    logic [15:0]         pick_avail;
    logic [LEN_W-1:0]    burst_len;

    logic                g_valid;
    logic [WORD_W-1:0]   g_data;
    logic [CHANNELS-1:0] g_onehot;

    // Per-channel decode: who has words, the picked channel's count, and the
    // granted channel's valid/data/ready position.
    always_comb begin
        avail_nz   = '0;
        pick_avail = '0;
        g_valid    = 1'b0;
        g_data     = '0;
        g_onehot   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            avail_nz[c] = |req_avail[16*c +: 16];
            if (pick_idx == 4'(c)) begin
                pick_avail = req_avail[16*c +: 16];
            end
            if (g_q == 4'(c)) begin
                g_valid     = req_valid[c];
                g_data      = req_data[16*c +: 16];
                g_onehot[c] = 1'b1;
            end
        end
    end

    rr_pick #(
        .N (CHANNELS)
    ) u_rr_pick (
        .req   (avail_nz),
        .ptr   (ptr_q),
        .grant (pick_onehot),
        .idx   (pick_idx)
    );

    assign pick_any = |pick_onehot;

    // Burst length: 16-bit unsigned min first, then keep the low 8 bits.
    assign burst_len = 8'((pick_avail < MAX_BURST_W) ? pick_avail : MAX_BURST_W);

    // Next-state logic and the combinational pipe-facing outputs.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_any) begin
                    g_d     = pick_idx;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                tx_valid = 1'b1;
                tx_data  = make_header(g_q, len_q);
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = g_valid;
                tx_data  = g_valid ? g_data : '0;
                if (g_valid && tx_ready) begin
                    req_ready = g_onehot;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_d == len_q) begin
                        state_d = ST_IDLE;
                        ptr_d   = g_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and burst-context registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= PTR_RESET;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_ch = g_q;

endmodule
